// File: rtl/fifo_umbrales.sv
// fifo_umbrales: per-lane synchronous FIFO with programmable almost-empty /
// almost-full thresholds and a sticky overflow/underflow error flag.
// Status flags are decoded from the registered occupancy count and the live
// threshold inputs, so they reflect contents as of the previous clock edge.
module fifo_umbrales #(
  parameter int DATA_WIDTH   = 6,
  parameter int ADDR_WIDTH   = 3,
  parameter int UMBRALES_L_H = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_enable,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_enable,
  input  logic [UMBRALES_L_H-1:0] umbral_L,
  input  logic [UMBRALES_L_H-1:0] umbral_H,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid_out,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_empty,
  output logic                    almost_full,
  output logic                    error_out,
  output logic [ADDR_WIDTH:0]     count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // Threshold compares are done at the wider of count and threshold widths.
  localparam int CW = (ADDR_WIDTH + 1 > UMBRALES_L_H) ? ADDR_WIDTH + 1 : UMBRALES_L_H;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  error_q, error_d;

  logic                  push_ok;
  logic                  pop_ok;
  logic [CW-1:0]         count_ext;
  logic [CW-1:0]         umbral_l_ext;
  logic [CW-1:0]         umbral_h_ext;

  assign count_ext    = CW'(count_q);
  assign umbral_l_ext = CW'(umbral_L);
  assign umbral_h_ext = CW'(umbral_H);

  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_FULL);
  assign almost_empty = (count_ext <= umbral_l_ext);
  assign almost_full  = (count_ext >= umbral_h_ext);

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign error_out = error_q;
  assign count     = count_q;

  // Decide which requests execute and compute next pointer/count/output state.
  always_comb begin
    pop_ok  = rd_enable && !empty;
    // A full FIFO still accepts a push when a pop frees a slot this cycle.
    push_ok = wr_enable && (!full || pop_ok);

    wr_ptr_d    = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    data_out_d  = pop_ok  ? mem_q[rd_ptr_q] : data_out_q;
    valid_out_d = pop_ok;

    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Dropped push means overflow; pop on empty means underflow. Sticky.
    error_d = error_q | (wr_enable && !push_ok) | (rd_enable && empty);
  end

  // Control and output registers; reset wins over any request this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      error_q     <= error_d;
    end
  end

  // Storage array; contents survive reset since count hides them.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_fifo_umbrales.sv
// Directed testbench for fifo_umbrales with a reference FIFO model and a
// scoreboard of expected pop data.
module tb_fifo_umbrales;

  logic       clk;
  logic       reset;
  logic       wr_enable;
  logic [5:0] data_in;
  logic       rd_enable;
  logic [7:0] umbral_L;
  logic [7:0] umbral_H;
  logic [5:0] data_out;
  logic       valid_out;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic       error_out;
  logic [3:0] count;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] mdl[$];
  logic [5:0] sb[$];
  logic       merr;

  fifo_umbrales #(
    .DATA_WIDTH(6),
    .ADDR_WIDTH(3),
    .UMBRALES_L_H(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_enable(wr_enable),
    .data_in(data_in),
    .rd_enable(rd_enable),
    .umbral_L(umbral_L),
    .umbral_H(umbral_H),
    .data_out(data_out),
    .valid_out(valid_out),
    .empty(empty),
    .full(full),
    .almost_empty(almost_empty),
    .almost_full(almost_full),
    .error_out(error_out),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags();
    int c;
    c = mdl.size();
    chk("count", 32'(count), 32'(c));
    chk("empty", 32'(empty), 32'(c == 0));
    chk("full", 32'(full), 32'(c == 8));
    chk("almost_empty", 32'(almost_empty), 32'(c <= int'(umbral_L)));
    chk("almost_full", 32'(almost_full), 32'(c >= int'(umbral_H)));
    chk("error_out", 32'(error_out), 32'(merr));
  endtask

  // One clock with the given requests, then compare against the model.
  task automatic cycle(input logic wr, input logic [5:0] din, input logic rd);
    bit ep, eh;
    ep = rd && (mdl.size() > 0);
    eh = wr && ((mdl.size() < 8) || ep);
    if ((wr && !eh) || (rd && mdl.size() == 0)) merr = 1'b1;
    if (ep) sb.push_back(mdl.pop_front());
    if (eh) mdl.push_back(din);
    wr_enable = wr;
    data_in   = din;
    rd_enable = rd;
    @(posedge clk);
    #1;
    wr_enable = 1'b0;
    rd_enable = 1'b0;
    chk("valid_out", 32'(valid_out), 32'(ep));
    if (valid_out === 1'b1) begin
      if (sb.size() > 0) chk("data_out", 32'(data_out), 32'(sb.pop_front()));
      else               chk("data_out_unexpected", 32'(data_out), 32'hFFFF_FFFF);
    end
    check_flags();
  endtask

  // Hold reset for n cycles (optionally with a push request asserted).
  task automatic do_reset(input int n, input logic wr);
    reset     = 1'b1;
    wr_enable = wr;
    data_in   = 6'h3E;
    rd_enable = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset     = 1'b0;
    wr_enable = 1'b0;
    mdl.delete();
    sb.delete();
    merr = 1'b0;
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    check_flags();
  endtask

  initial begin
    reset     = 1'b1;
    wr_enable = 1'b0;
    rd_enable = 1'b0;
    data_in   = '0;
    umbral_L  = 8'd2;
    umbral_H  = 8'd6;
    merr      = 1'b0;

    // Reset
    do_reset(2, 1'b0);

    // Fill 0x01..0x08
    for (int i = 1; i <= 8; i++) cycle(1'b1, 6'(i), 1'b0);

    // Overflow, then drain in order
    cycle(1'b1, 6'h3F, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 6'h00, 1'b1);
    cycle(1'b0, 6'h00, 1'b0);

    // Wrap with simultaneous push/pop
    do_reset(1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 6'(6'h10 + i), 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 6'(6'h20 + i), 1'b1);
    // Full with simultaneous push/pop keeps count at DEPTH
    for (int i = 0; i < 3; i++) cycle(1'b1, 6'(6'h30 + i), 1'b0);
    cycle(1'b1, 6'h05, 1'b1);

    // Underflow with push, no fall-through
    do_reset(1, 1'b0);
    cycle(1'b1, 6'h2A, 1'b1);
    cycle(1'b0, 6'h00, 1'b1);

    // Live thresholds, including out-of-range values
    do_reset(1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 6'(6'h08 + i), 1'b0);
    umbral_H = 8'd4;
    #1;
    check_flags();
    umbral_H = 8'd9;
    umbral_L = 8'd9;
    #1;
    check_flags();
    umbral_L = 8'd2;

    // Reset mid-fill with a concurrent push
    do_reset(1, 1'b1);
    umbral_H = 8'd0;
    #1;
    check_flags();
    umbral_H = 8'd6;
    cycle(1'b1, 6'h15, 1'b0);
    cycle(1'b0, 6'h00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_umbrales.md
# fifo_umbrales

Synchronous FIFO with programmable almost-empty/almost-full thresholds, one instance per lane. Consumes the `umbral_L_out`/`umbral_H_out` thresholds produced by the `fsm` block. Produces the `empty_fifo_N` status that `fsm` uses to detect idle. Count-based flags are derived from registered state, so every flag reflects the FIFO contents as of the previous clock edge.

## Interface
- `DATA_WIDTH`, default 6: width of a data word.
- `ADDR_WIDTH`, default 3: pointer width. Depth is `DEPTH = 2**ADDR_WIDTH`, which is 8 by default.
- `UMBRALES_L_H`, default 8: width of the threshold inputs.

Ports:
- `clk`  in  1: single clock. All logic is on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `wr_enable`  in  1: push request; `data_in` is written this cycle.
- `data_in`  in  `DATA_WIDTH`: push data.
- `rd_enable`  in  1: pop request.
- `umbral_L`  in  `UMBRALES_L_H`: almost-empty threshold, sampled live every cycle.
- `umbral_H`  in  `UMBRALES_L_H`: almost-full threshold, sampled live every cycle.
- `data_out`  out  `DATA_WIDTH`: registered pop data.
- `valid_out`  out  1: `data_out` holds a popped word this cycle.
- `empty`  out  1: count == 0. Drives `empty_fifo_N` of `fsm`.
- `full`  out  1: count == `DEPTH`.
- `almost_empty`  out  1: count <= `umbral_L`.
- `almost_full`  out  1: count >= `umbral_H`.
- `error_out`  out  1: sticky flag for overflow or underflow.
- `count`  out  `ADDR_WIDTH+1`: current occupancy, 0..`DEPTH`.

## Operation
**Storage**
- `DEPTH` x `DATA_WIDTH` register array.
- `wr_ptr` and `rd_ptr` are `ADDR_WIDTH` bits and wrap modulo `DEPTH` with no special case.
- `count` is an explicit `ADDR_WIDTH+1`-bit register.

**Push**
- When `wr_enable` and the push is accepted: `mem[wr_ptr] <= data_in`, `wr_ptr` increments.
- Accepted when not `full`, or when `full` and a pop executes in the same cycle.

**Pop**
- When `rd_enable` and not `empty`: `data_out <= mem[rd_ptr]`, `valid_out <= 1`, `rd_ptr` increments.
- Otherwise `valid_out <= 0` and `data_out` holds its last value.

**Count update**
- +1 on an accepted push alone.
- −1 on an executed pop alone.
- Unchanged on both, or on neither.

**Overflow**
- `wr_enable` while `full` with no executed pop: the write is dropped, pointers and count are unchanged, and `error_out <= 1`.

**Underflow**
- `rd_enable` while `empty`: the pop is ignored and `error_out <= 1`.
- A simultaneous push still executes, so count becomes 1. There is no fall-through: the pushed word is not popped this cycle.

**Error flag**
- `error_out` stays high until `reset`.

**Flags**
- `empty`, `full`, `almost_empty` and `almost_full` are combinational from the registered `count` and the live thresholds.
- Comparisons zero-extend `count` to `max(ADDR_WIDTH+1, UMBRALES_L_H)` bits.
- A threshold above `DEPTH` is legal: `almost_full` then never asserts, and `almost_empty` is always asserted.

## Timing
**Reset**
- Reset has priority over push and pop in the same cycle.
- Next cycle values: pointers = 0, `count` = 0, `data_out` = 0, `valid_out` = 0, `error_out` = 0.
- Resulting flags: `empty` = 1, `full` = 0, `almost_empty` = 1.
- `almost_full` = 1 only if `umbral_H` == 0.
- Memory contents are not cleared. They are unobservable because `count` = 0.

**Latency**
- Push to `empty` deassert: 1 cycle (visible after the edge that captures the push).
- Pop to `data_out`/`valid_out`: 1 cycle, registered.
- Flags follow `count` in the same cycle it changes.
- A threshold change affects `almost_*` combinationally, with 0 cycles of latency.

**Throughput**
- One push and one pop per cycle, sustained, at any occupancy except the underflow and overflow cases above.

**Reset mid-operation**
- Pending data is discarded.
- The first push after reset lands at address 0.

## Test plan
1. **Reset:** assert `reset` 2 cycles with `umbral_L`=2, `umbral_H`=6 -> `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0, `count`=0, `valid_out`=0, `error_out`=0.
2. **Fill:** push 0x01..0x08 on 8 consecutive cycles with L=2, H=6.
   - `almost_empty` drops when `count` goes 2->3.
   - `almost_full` rises when `count` reaches 6.
   - `full`=1 at `count`=8.
   - `error_out` stays 0.
3. **Overflow:** at full, push 0x3F alone -> `count` stays 8 and `error_out`=1 sticky. Then pop 8 -> `data_out` returns 0x01..0x08 in order, each one cycle after its `rd_enable`, and `empty`=1 at the end.
4. **Wrap and simultaneous:** preload 5 words, then push and pop together for 12 cycles -> `count` stays 5, data stays in order across the pointer wrap, and `valid_out`=1 every cycle.
5. **Underflow with push:** on an empty FIFO, assert `rd_enable`, `wr_enable` and `data_in`=0x2A together -> `valid_out`=0 and `error_out`=1. Next cycle `count`=1 and `empty`=0. Then pop -> `data_out`=0x2A.
6. **Live thresholds / reset mid-fill:** at `count`=4, set H from 6 to 4 -> `almost_full`=1 the same cycle. Then assert `reset` together with `wr_enable` -> next cycle `count`=0, the write is dropped and `error_out`=0.
